imm_ext_stage: RTL and testbench



---
 rtl/imm_ext_stage_if.sv | 32 +++
 rtl/imm_ext_stage.sv | 150 +++++++++++++++
 tb/tb_imm_ext_stage.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_stage_if.sv
// imm_ext_stage_if: handshake bundle for the immediate-extension stage.
// Signal names are written from the stage's point of view; the stage uses
// the slave modport and whatever feeds/drains it uses the master modport.
interface imm_ext_stage_if #(
  parameter int XLEN      = 64,
  parameter int IMM_WIDTH = 25,
  parameter int TAG_WIDTH = 8
);
  // upstream side
  logic                 i_valid;
  logic                 o_ready;
  logic [2:0]           i_control_signal;
  logic [IMM_WIDTH-1:0] i_imm;
  logic [TAG_WIDTH-1:0] i_tag;

  // downstream side
  logic                 o_valid;
  logic                 i_ready;
  logic [XLEN-1:0]      o_imm_ext;
  logic [TAG_WIDTH-1:0] o_tag;
  logic                 o_illegal;

  modport slave (
    input  i_valid, i_control_signal, i_imm, i_tag, i_ready,
    output o_ready, o_valid, o_imm_ext, o_tag, o_illegal
  );

  modport master (
    output i_valid, i_control_signal, i_imm, i_tag, i_ready,
    input  o_ready, o_valid, o_imm_ext, o_tag, o_illegal
  );
endinterface

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered RISC-V immediate extender with a 2-entry skid
// buffer. The raw field is instr[31:7]; extension happens before the
// registers so the output side is a plain register read.
module imm_ext_stage #(
  parameter int XLEN      = 64,
  parameter int IMM_WIDTH = 25,
  parameter int TAG_WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  imm_ext_stage_if.slave   io_bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_ext_stage: XLEN must be 32 or 64");
  end
  if (IMM_WIDTH != 25) begin : g_bad_imm_width
    $error("imm_ext_stage: IMM_WIDTH must be 25");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("imm_ext_stage: TAG_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [XLEN-1:0]      r_out_imm;
  logic [TAG_WIDTH-1:0] r_out_tag;
  logic                 r_out_ill;
  logic [XLEN-1:0]      r_skid_imm;
  logic [TAG_WIDTH-1:0] r_skid_tag;
  logic                 r_skid_ill;

  logic [XLEN-1:0]      w_imm_ext;
  logic                 w_illegal;
  logic                 w_ready;
  logic                 w_valid;
  logic                 w_accept;
  logic                 w_drain;
  logic                 w_load_out_in;
  logic                 w_load_out_skid;
  logic                 w_load_skid;

  // Decode the format and sign/zero-extend the incoming field to XLEN.
  always_comb begin
    w_imm_ext = '0;
    w_illegal = 1'b0;
    case (io_bus.i_control_signal)
      3'b000: w_imm_ext = XLEN'($signed(io_bus.i_imm[24:13]));
      3'b001: w_imm_ext = XLEN'($signed({io_bus.i_imm[24:18], io_bus.i_imm[4:0]}));
      3'b010: w_imm_ext = XLEN'($signed({io_bus.i_imm[24], io_bus.i_imm[0],
                                         io_bus.i_imm[23:18], io_bus.i_imm[4:1], 1'b0}));
      3'b011: w_imm_ext = XLEN'($signed({io_bus.i_imm[24], io_bus.i_imm[12:5],
                                         io_bus.i_imm[13], io_bus.i_imm[23:14], 1'b0}));
      3'b100: w_imm_ext = XLEN'($signed({io_bus.i_imm[24:5], 12'b0}));
      3'b101: w_imm_ext = XLEN'(io_bus.i_imm[12:8]);
      default: w_illegal = 1'b1;
    endcase
  end

  // State register; reset and flush both land in EMPTY.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Occupancy transitions; flush wins over any accept or drain.
  always_comb begin
    w_next_state = r_state;
    if (i_flush) begin
      w_next_state = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) w_next_state = ONE;
        ONE: begin
          if (w_accept && !w_drain) w_next_state = FULL;
          else if (!w_accept && w_drain) w_next_state = EMPTY;
        end
        FULL: if (w_drain) w_next_state = ONE;
        default: w_next_state = EMPTY;
      endcase
    end
  end

  // Handshake outputs and register load strobes; ready never looks at i_ready.
  always_comb begin
    w_ready         = ~i_flush & (r_state != FULL);
    w_valid         = (r_state != EMPTY);
    w_accept        = io_bus.i_valid & w_ready;
    w_drain         = w_valid & io_bus.i_ready;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (!i_flush) begin
      case (r_state)
        EMPTY: w_load_out_in = w_accept;
        ONE: begin
          w_load_out_in = w_accept & w_drain;
          w_load_skid   = w_accept & ~w_drain;
        end
        FULL: w_load_out_skid = w_drain;
        default: ;
      endcase
    end
  end

  // Entry storage: OUT is refilled from the input or the skid, SKID from the input.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_imm  <= '0;
      r_out_tag  <= '0;
      r_out_ill  <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_load_out_in) begin
        r_out_imm <= w_imm_ext;
        r_out_tag <= io_bus.i_tag;
        r_out_ill <= w_illegal;
      end else if (w_load_out_skid) begin
        r_out_imm <= r_skid_imm;
        r_out_tag <= r_skid_tag;
        r_out_ill <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_imm_ext;
        r_skid_tag <= io_bus.i_tag;
        r_skid_ill <= w_illegal;
      end
    end
  end

  assign io_bus.o_ready   = w_ready;
  assign io_bus.o_valid   = w_valid;
  assign io_bus.o_imm_ext = r_out_imm;
  assign io_bus.o_tag     = r_out_tag;
  assign io_bus.o_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: drives an XLEN=64 and an XLEN=32 instance in lockstep.
// Accepted entries are turned into expected results by a reference model
// built from the RISC-V instruction-field definitions; a monitor consumes
// them in order as each instance drains its output.
module tb_imm_ext_stage;

  localparam int TW = 8;

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
    int          acc;
    bit          strm;
  } item_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        drvFlush;
  logic        drvValid;
  logic        drvReady;
  logic        drvStream;
  logic [2:0]  drvCtrl;
  logic [24:0] drvImm;
  logic [7:0]  drvTag;

  int          checkCount = 0;
  int          failCount  = 0;
  int          cycle      = 0;

  item_t       expList[$];
  int          head[2] = '{0, 0};
  logic        prevHold[2] = '{1'b0, 1'b0};
  logic [63:0] prevImm[2];
  logic [7:0]  prevTag[2];
  logic        prevIll[2];

  imm_ext_stage_if #(.XLEN(64), .IMM_WIDTH(25), .TAG_WIDTH(TW)) bus64 ();
  imm_ext_stage_if #(.XLEN(32), .IMM_WIDTH(25), .TAG_WIDTH(TW)) bus32 ();

  assign bus64.i_valid          = drvValid;
  assign bus64.i_control_signal = drvCtrl;
  assign bus64.i_imm            = drvImm;
  assign bus64.i_tag            = drvTag;
  assign bus64.i_ready          = drvReady;
  assign bus32.i_valid          = drvValid;
  assign bus32.i_control_signal = drvCtrl;
  assign bus32.i_imm            = drvImm;
  assign bus32.i_tag            = drvTag;
  assign bus32.i_ready          = drvReady;

  imm_ext_stage #(.XLEN(64), .IMM_WIDTH(25), .TAG_WIDTH(TW)) dut64 (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_flush (drvFlush),
    .io_bus  (bus64)
  );

  imm_ext_stage #(.XLEN(32), .IMM_WIDTH(25), .TAG_WIDTH(TW)) dut32 (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_flush (drvFlush),
    .io_bus  (bus32)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Cycle count used to measure accept-to-output latency.
  always @(posedge clk) cycle <= cycle + 1;

  function automatic longint sext(input longint raw, input int w);
    if (raw[w-1]) return raw - (longint'(1) << w);
    return raw;
  endfunction

  // Reference: rebuild instr[31:0] and apply the ISA immediate layouts.
  function automatic logic [63:0] refImm(input logic [2:0] c, input logic [24:0] f,
                                         output logic ill);
    logic [31:0] instr;
    longint      v;
    instr = {f, 7'b0};
    v     = 0;
    ill   = 1'b0;
    case (c)
      3'd0: v = sext(longint'(instr[31:20]), 12);
      3'd1: v = sext(longint'({instr[31:25], instr[11:7]}), 12);
      3'd2: v = sext(longint'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), 13);
      3'd3: v = sext(longint'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), 21);
      3'd4: v = sext(longint'({instr[31:12], 12'b0}), 32);
      3'd5: v = longint'(instr[19:15]);
      default: ill = 1'b1;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Present one entry and hold it until the stage takes it; ends at posedge+1.
  task automatic applyStimulus(input logic [2:0] c, input logic [24:0] imm, input logic [7:0] tag);
    int waitCnt = 0;
    drvCtrl  = c;
    drvImm   = imm;
    drvTag   = tag;
    drvValid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus64.o_ready === 1'b1) break;
      waitCnt++;
      if (waitCnt > 100) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL accept_timeout: o_ready stayed 0 for %0d cycles, required 1", waitCnt);
        break;
      end
    end
    @(posedge clk);
    #1;
    drvValid = 1'b0;
  endtask

  // Single entry with i_ready high; its result must be on the output next cycle.
  task automatic directedCheck(input string nm, input logic [2:0] c, input logic [24:0] imm,
                               input logic [7:0] tag, input logic [63:0] e64,
                               input logic [63:0] e32, input logic eIll);
    drvReady = 1'b1;
    applyStimulus(c, imm, tag);
    @(negedge clk);
    checkOutput({nm, "_valid"},   64'(bus64.o_valid),   64'd1);
    checkOutput({nm, "_imm64"},   bus64.o_imm_ext,      e64);
    checkOutput({nm, "_imm32"},   64'(bus32.o_imm_ext), e32);
    checkOutput({nm, "_tag"},     64'(bus64.o_tag),     64'(tag));
    checkOutput({nm, "_illegal"}, 64'(bus64.o_illegal), 64'(eIll));
    @(posedge clk);
    #1;
  endtask

  // Record every accepted entry with its expected result; flush/reset discard all pending.
  always @(negedge clk) begin : scoreboardPush
    item_t it;
    logic  ill;
    #1;
    if (!rstN || drvFlush) begin
      head[0] = expList.size();
      head[1] = expList.size();
    end else if (drvValid && bus64.o_ready === 1'b1) begin
      it.imm  = refImm(drvCtrl, drvImm, ill);
      it.ill  = ill;
      it.tag  = drvTag;
      it.acc  = cycle;
      it.strm = drvStream;
      expList.push_back(it);
    end
  end

  // Check handshake against occupancy, output stability under stall, and drained data.
  always @(negedge clk) begin : monitor
    for (int p = 0; p < 2; p++) begin
      logic        v;
      logic        r;
      logic        il;
      logic [63:0] imm;
      logic [63:0] eImm;
      logic [7:0]  tg;
      int          pend;
      item_t       e;
      v    = (p == 0) ? bus64.o_valid   : bus32.o_valid;
      r    = (p == 0) ? bus64.o_ready   : bus32.o_ready;
      il   = (p == 0) ? bus64.o_illegal : bus32.o_illegal;
      tg   = (p == 0) ? bus64.o_tag     : bus32.o_tag;
      imm  = (p == 0) ? bus64.o_imm_ext : 64'(bus32.o_imm_ext);
      pend = expList.size() - head[p];
      checkOutput($sformatf("o_ready_p%0d", p), 64'(r), 64'(!drvFlush && pend < 2));
      checkOutput($sformatf("o_valid_p%0d", p), 64'(v), 64'(pend > 0));
      if (prevHold[p]) begin
        checkOutput($sformatf("hold_imm_p%0d", p), imm,     prevImm[p]);
        checkOutput($sformatf("hold_tag_p%0d", p), 64'(tg), 64'(prevTag[p]));
        checkOutput($sformatf("hold_ill_p%0d", p), 64'(il), 64'(prevIll[p]));
      end
      if (v === 1'b1 && drvReady && pend > 0) begin
        e    = expList[head[p]];
        head[p]++;
        eImm = (p == 0) ? e.imm : (e.imm & 64'h0000_0000_FFFF_FFFF);
        checkOutput($sformatf("imm_p%0d", p), imm,     eImm);
        checkOutput($sformatf("tag_p%0d", p), 64'(tg), 64'(e.tag));
        checkOutput($sformatf("ill_p%0d", p), 64'(il), 64'(e.ill));
        if (e.strm) checkOutput($sformatf("latency_p%0d", p), 64'(cycle - e.acc), 64'd1);
        else        checkOutput($sformatf("latency_min_p%0d", p), 64'(cycle > e.acc), 64'd1);
      end
      prevHold[p] = (v === 1'b1) && !drvReady && !drvFlush && rstN;
      prevImm[p]  = imm;
      prevTag[p]  = tg;
      prevIll[p]  = il;
    end
  end

  // Guard against a hung run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    rstN      = 1'b0;
    drvFlush  = 1'b0;
    drvValid  = 1'b0;
    drvReady  = 1'b0;
    drvStream = 1'b0;
    drvCtrl   = 3'd0;
    drvImm    = '0;
    drvTag    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(bus64.o_valid),   64'd0);
    checkOutput("rst_imm64", bus64.o_imm_ext,      64'd0);
    checkOutput("rst_imm32", 64'(bus32.o_imm_ext), 64'd0);
    checkOutput("rst_tag",   64'(bus64.o_tag),     64'd0);
    checkOutput("rst_ill",   64'(bus64.o_illegal), 64'd0);
    checkOutput("rst_ready", 64'(bus64.o_ready),   64'd1);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed format vectors");
    directedCheck("addi_m1", 3'b000, 25'h1FFE001, 8'h01,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    directedCheck("lui",     3'b100, 25'h1000001, 8'h02,
                  64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 1'b0);
    directedCheck("csr",     3'b101, 25'h1001F00, 8'h03,
                  64'h1F, 64'h1F, 1'b0);
    directedCheck("illegal", 3'b110, 25'($urandom), 8'h5A,
                  64'd0, 64'd0, 1'b1);

    $display("[TB] backpressure A,B,C");
    drvReady = 1'b0;
    applyStimulus(3'b000, 25'($urandom), 8'hA1);
    applyStimulus(3'b001, 25'($urandom), 8'hB2);
    fork
      applyStimulus(3'b010, 25'($urandom), 8'hC3);
      begin
        @(negedge clk);
        checkOutput("bp_ready_full", 64'(bus64.o_ready), 64'd0);
        checkOutput("bp_head_tag",   64'(bus64.o_tag),   64'hA1);
        repeat (2) @(negedge clk);
        checkOutput("bp_ready_held", 64'(bus64.o_ready), 64'd0);
        @(posedge clk);
        #1;
        drvReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_out0_tag", 64'(bus64.o_tag), 64'hA1);
        @(negedge clk);
        checkOutput("bp_out1_tag", 64'(bus64.o_tag), 64'hB2);
        @(negedge clk);
        checkOutput("bp_out2_tag",   64'(bus64.o_tag),   64'hC3);
        checkOutput("bp_out2_valid", 64'(bus64.o_valid), 64'd1);
      end
    join
    @(posedge clk);
    #1;

    $display("[TB] streaming 100 random entries");
    drvReady  = 1'b1;
    drvStream = 1'b1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 25'($urandom), 8'($urandom));
    end
    drvStream = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] flush while full");
    drvReady = 1'b0;
    applyStimulus(3'b011, 25'($urandom), 8'h11);
    applyStimulus(3'b100, 25'($urandom), 8'h22);
    drvCtrl  = 3'b000;
    drvImm   = 25'($urandom);
    drvTag   = 8'h33;
    drvValid = 1'b1;
    drvFlush = 1'b1;
    @(negedge clk);
    checkOutput("flush_ready", 64'(bus64.o_ready), 64'd0);
    @(posedge clk);
    #1;
    drvFlush = 1'b0;
    drvValid = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid_after", 64'(bus64.o_valid), 64'd0);
    checkOutput("flush_ready_after", 64'(bus64.o_ready), 64'd1);
    @(posedge clk);
    #1;
    drvReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] reset with one entry held");
    drvReady = 1'b0;
    applyStimulus(3'b001, 25'($urandom), 8'h44);
    rstN     = 1'b0;
    drvCtrl  = 3'b100;
    drvImm   = 25'($urandom);
    drvTag   = 8'h55;
    drvValid = 1'b1;
    @(posedge clk);
    #1;
    rstN     = 1'b1;
    drvValid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(bus64.o_valid),   64'd0);
    checkOutput("midrst_imm64", bus64.o_imm_ext,      64'd0);
    checkOutput("midrst_imm32", 64'(bus32.o_imm_ext), 64'd0);
    checkOutput("midrst_tag",   64'(bus64.o_tag),     64'd0);
    checkOutput("midrst_ill",   64'(bus64.o_illegal), 64'd0);
    checkOutput("midrst_ready", 64'(bus64.o_ready),   64'd1);
    @(posedge clk);
    #1;
    directedCheck("jal_m4", 3'b011, 25'h1FFBFE0, 8'h66,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFC, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
